gcd_binary_unit: RTL and testbench

//  Parametrised successor GCD engine using the binary (Stein) algorithm: shift/compare/subtract only, no divider.

---
 rtl/gcd_pkg.sv | 19 +
 rtl/gcd_cmp_sub.sv | 25 ++
 rtl/gcd_binary_unit.sv | 202 ++++++++++++++++++++
 tb/tb_gcd_binary_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg
//   Shared types and helpers for the binary GCD engine.
//   gcd_state_t : controller states of gcd_binary_unit
//   gcd_max_lat : worst-case clock edges from accepted start to done rising
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        EVEN,
        REDUCE,
        FINISH
    } gcd_state_t;

    function automatic int gcd_max_lat(input int w);
        return 2 * w + 3;
    endfunction

endpackage

// File: rtl/gcd_cmp_sub.sv
// gcd_cmp_sub
//   Combinational compare/subtract slice for the binary GCD reduce step.
//   Ports:
//     x, y     in  WIDTH  unsigned operands
//     gt       out 1      x > y
//     eq       out 1      x == y
//     diff_ab  out WIDTH  x - y (only meaningful when x >= y)
//     diff_ba  out WIDTH  y - x (only meaningful when y >= x)
module gcd_cmp_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             gt,
    output logic             eq,
    output logic [WIDTH-1:0] diff_ab,
    output logic [WIDTH-1:0] diff_ba
);

    assign gt      = (x > y);
    assign eq      = (x == y);
    assign diff_ab = x - y;
    assign diff_ba = y - x;

endmodule

// File: rtl/gcd_binary_unit.sv
// gcd_binary_unit
//   Binary (Stein) GCD engine: shift/compare/subtract only, one job per
//   accepted start, result held until the next accepted start.
//   Ports:
//     clk       in   1      rising-edge clock
//     reset     in   1      synchronous active-high reset
//     start     in   1      job request, taken only in IDLE (busy==0)
//     a, b      in   WIDTH  operands, captured on accepted start
//     busy      out  1      job in progress
//     done      out  1      result valid (level), cleared on next accepted start
//     result    out  WIDTH  gcd(a,b)
//     zero_err  out  1      both operands were zero (result 0)
//     cycles    out  CNT_W  edges from accepted start to done rise
//                           (present only with GCD_CYCLE_COUNT_EN defined)
//   Optional feature macro: GCD_CYCLE_COUNT_EN
//
//   state  | meaning
//   IDLE   | waiting for start, outputs held
//   INIT   | zero-operand and equal-operand shortcuts
//   EVEN   | strip common factors of two into k
//   REDUCE | odd/even reduction until ra == rb
//   FINISH | publish done, drop busy
module gcd_binary_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_err
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [$clog2(2*WIDTH+4)-1:0] cycles
`endif
);

    localparam int K_W = $clog2(WIDTH + 1);

    gcd_state_t       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_err_q, zero_err_d;

`ifdef GCD_CYCLE_COUNT_EN
    localparam int CNT_W = $clog2(2 * WIDTH + 4);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
`endif

    logic             cmp_gt;
    logic             cmp_eq;
    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] diff_ba;

    gcd_cmp_sub #(.WIDTH(WIDTH)) u_cmp (
        .x       (ra_q),
        .y       (rb_q),
        .gt      (cmp_gt),
        .eq      (cmp_eq),
        .diff_ab (diff_ab),
        .diff_ba (diff_ba)
    );

    always_comb begin
        state_d    = state_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        k_d        = k_q;
        busy_d     = busy_q;
        done_d     = done_q;
        result_d   = result_q;
        zero_err_d = zero_err_q;
`ifdef GCD_CYCLE_COUNT_EN
        cnt_d      = busy_q ? cnt_q + 1'b1 : cnt_q;
        cycles_d   = cycles_q;
`endif

        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    ra_d       = a;
                    rb_d       = b;
                    k_d        = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    zero_err_d = 1'b0;
                    state_d    = INIT;
`ifdef GCD_CYCLE_COUNT_EN
                    cnt_d      = CNT_W'(1);
`endif
                end
            end

            INIT: begin
                // With a zero operand the OR is the other operand (or 0 for 0,0).
                // Equal operands finish immediately so that case stays at
                // minimum latency.
                if (ra_q == '0 || rb_q == '0) begin
                    result_d = ra_q | rb_q;
                    state_d  = FINISH;
                end else if (cmp_eq) begin
                    result_d = ra_q;
                    state_d  = FINISH;
                end else begin
                    state_d  = EVEN;
                end
            end

            EVEN: begin
                if (!ra_q[0] && !rb_q[0]) begin
                    ra_d = ra_q >> 1;
                    rb_d = rb_q >> 1;
                    k_d  = k_q + 1'b1;
                end else begin
                    state_d = REDUCE;
                end
            end

            REDUCE: begin
                // Subtraction only happens with both values odd, so the
                // difference is even and is halved in the same cycle; every
                // action shortens the operands, which bounds the latency.
                if (!ra_q[0]) begin
                    ra_d = ra_q >> 1;
                end else if (!rb_q[0]) begin
                    rb_d = rb_q >> 1;
                end else if (cmp_gt) begin
                    ra_d = diff_ab >> 1;
                end else if (!cmp_eq) begin
                    rb_d = diff_ba >> 1;
                end else begin
                    result_d = ra_q << k_q;
                    state_d  = FINISH;
                end
            end

            FINISH: begin
                // A zero result is only possible when both operands were zero.
                done_d     = 1'b1;
                busy_d     = 1'b0;
                zero_err_d = (result_q == '0);
                state_d    = IDLE;
`ifdef GCD_CYCLE_COUNT_EN
                cycles_d   = cnt_q;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ra_q       <= '0;
            rb_q       <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zero_err_q <= 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
            cnt_q      <= '0;
            cycles_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            zero_err_q <= zero_err_d;
`ifdef GCD_CYCLE_COUNT_EN
            cnt_q      <= cnt_d;
            cycles_q   <= cycles_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zero_err = zero_err_q;
`ifdef GCD_CYCLE_COUNT_EN
    assign cycles   = cycles_q;
`endif

endmodule

// File: tb/tb_gcd_binary_unit.sv
// tb_gcd_binary_unit
//   Directed and swept operand pairs against a Euclid reference model,
//   with a free-running compare process checking every cycle done is high.
module tb_gcd_binary_unit;
    import gcd_pkg::*;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 60;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero_err;
`ifdef GCD_CYCLE_COUNT_EN
    logic [$clog2(2*WIDTH+4)-1:0] cycles;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_result = 0;
    int exp_zero   = 0;
    int max_lat;

    gcd_binary_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero_err (zero_err)
`ifdef GCD_CYCLE_COUNT_EN
        ,
        .cycles   (cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic int ref_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    a_done_not_busy: assert property (@(posedge clk) disable iff (reset) done |-> !busy)
        else begin
            failures++;
            $display("FAIL done_not_busy: busy=%0b while done=%0b", busy, done);
        end

    // Compare process: whenever a result is published it must match the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!reset && done) begin
                check("cmp_result", int'(result), exp_result);
                check("cmp_zero_err", int'(zero_err), exp_zero);
            end
        end
    end

    task automatic do_job(input int x, input int y, input int lit, input int lat_max);
        int lat;
        bit got;
        lat = 0;
        @(negedge clk);
        while (busy && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        exp_result = ref_gcd(x, y);
        exp_zero   = (x == 0 && y == 0) ? 1 : 0;
        a     = x[WIDTH-1:0];
        b     = y[WIDTH-1:0];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) got = 1'b1;
        end
        checks++;
        if (!got || lat > lat_max) begin
            failures++;
            $display("FAIL latency a=%0d b=%0d: got %0d edges (done_seen=%0b) expected <= %0d",
                     x, y, lat, got, lat_max);
        end
        if (lit >= 0) check($sformatf("literal_%0d_%0d", x, y), int'(result), lit);
`ifdef GCD_CYCLE_COUNT_EN
        check("cycles", int'(cycles), lat);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        bit prev_done;
        max_lat = gcd_max_lat(WIDTH);
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_zero_err", int'(zero_err), 0);
        @(negedge clk) reset = 1'b0;

        do_job(48, 18, 6, max_lat);
        check("zero_err_48_18", int'(zero_err), 0);
        do_job(0, 0, 0, max_lat);
        check("zero_err_0_0", int'(zero_err), 1);
        do_job(0, 35, 35, max_lat);
        do_job(200, 0, 200, max_lat);
        check("zero_err_200_0", int'(zero_err), 0);
        do_job(255, 255, 255, 3);
        do_job(128, 96, 32, max_lat);
        do_job(255, 254, 1, max_lat);
        do_job(255, 1, 1, max_lat);
        do_job(1, 255, 1, max_lat);
        do_job(129, 255, 3, max_lat);
        do_job(171, 85, 1, max_lat);

        for (int x = 1; x <= 255; x += 17)
            for (int y = 1; y <= 255; y += 13)
                do_job(x, y, -1, max_lat);
        for (int i = 0; i < 40; i++)
            do_job(int'($urandom_range(1, 255)), int'($urandom_range(1, 255)), -1, max_lat);

        // Start pulse while busy must be ignored.
        @(negedge clk);
        exp_result = ref_gcd(100, 75);
        exp_zero   = 0;
        a = 8'd100;
        b = 8'd75;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'd9;
        b = 8'd6;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        rises = 0;
        prev_done = done;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done && !prev_done) rises++;
            prev_done = done;
        end
        check("busy_reject_rises", rises, 1);
        check("busy_reject_result", int'(result), 25);
        check("busy_reject_idle", int'(busy), 0);

        // Reset mid-job.
        @(negedge clk);
        a = 8'd252;
        b = 8'd198;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_result", int'(result), 0);
        @(negedge clk) reset = 1'b0;
        do_job(21, 14, 7, max_lat);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
